// File: rtl/t_leaf_port.sv
// t_leaf_port: leaf endpoint of the deflection fat-tree. Client packets are queued in a
// TX FIFO and injected; packets for this leaf land in an RX FIFO; everything else bounces.

// Show-ahead circular FIFO with a registered occupancy counter.
module t_leaf_fifo #(
  parameter int width = 1,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int pw = $clog2(depth);
  localparam logic [pw:0] depth_c = (pw+1)'(depth);

  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];
  logic [pw-1:0]    wr_ptr_q, wr_ptr_d;
  logic [pw-1:0]    rd_ptr_q, rd_ptr_d;
  logic [pw:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == depth_c);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + pw'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + pw'(1);
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (pw+1)'(1);
      2'b01:   cnt_d = cnt_q - (pw+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// Handshakes: a transfer happens on a rising edge where valid && ready are both high;
// valid never depends on ready, and the offered data is held stable until it transfers.
module t_leaf_port #(
  parameter int num_leaves = 2,
  parameter int payload_sz = 1,
  parameter logic [$clog2(num_leaves)-1:0] addr = '0,
  parameter int p_sz = 1 + $clog2(num_leaves) + payload_sz,
  parameter int fifo_depth = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [p_sz-1:0]               bus_i,
  output logic [p_sz-1:0]               bus_o,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [$clog2(num_leaves)-1:0] tx_dest,
  input  logic [payload_sz-1:0]         tx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [payload_sz-1:0]         rx_data,
  output logic                          rx_src_ok,
  output logic [15:0]                   bounce_cnt
);
  localparam int aw = $clog2(num_leaves);

  logic                  pkt_valid;
  logic [aw-1:0]         pkt_dest;
  logic [payload_sz-1:0] pkt_payload;

  logic                  tx_full, tx_empty, tx_push, tx_pop;
  logic [p_sz-1:0]       tx_head;
  logic                  rx_full, rx_empty, rx_pop;
  logic [payload_sz-1:0] rx_head;

  logic                  accept, bounce;
  logic [p_sz-1:0]       bus_o_q, bus_o_d;
  logic [15:0]           bounce_cnt_q, bounce_cnt_d;

  assign pkt_valid   = bus_i[p_sz-1];
  assign pkt_dest    = bus_i[p_sz-2 -: aw];
  assign pkt_payload = bus_i[payload_sz-1:0];

  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && tx_ready;

  assign rx_valid  = !rx_empty;
  assign rx_pop    = rx_valid && rx_ready;
  assign rx_data   = rx_valid ? rx_head : '0;
  assign rx_src_ok = rx_valid;

  assign bus_o      = bus_o_q;
  assign bounce_cnt = bounce_cnt_q;

  t_leaf_fifo #(.width(p_sz), .depth(fifo_depth)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (p_sz'({1'b1, tx_dest, tx_data})),
    .pop       (tx_pop),
    .head      (tx_head),
    .empty     (tx_empty),
    .full      (tx_full)
  );

  t_leaf_fifo #(.width(payload_sz), .depth(fifo_depth)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (pkt_payload),
    .pop       (rx_pop),
    .head      (rx_head),
    .empty     (rx_empty),
    .full      (rx_full)
  );

  always_comb begin
    accept = 1'b0;
    bounce = 1'b0;
    // rx_full is pre-edge occupancy, so a same-cycle client pop cannot make room.
    if (pkt_valid) begin
      if (pkt_dest == addr && !rx_full) begin
        accept = 1'b1;
      end else begin
        bounce = 1'b1;
      end
    end
    tx_pop  = !bounce && !tx_empty;
    bus_o_d = '0;
    if (bounce) begin
      bus_o_d = bus_i;
    end else if (tx_pop) begin
      bus_o_d = tx_head;
    end
    bounce_cnt_d = bounce_cnt_q;
    if (bounce && bounce_cnt_q != 16'hFFFF) begin
      bounce_cnt_d = bounce_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_o_q      <= '0;
      bounce_cnt_q <= '0;
    end else begin
      bus_o_q      <= bus_o_d;
      bounce_cnt_q <= bounce_cnt_d;
    end
  end
endmodule

// File: doc/t_leaf_port.md
# t_leaf_port

Leaf-side endpoint of the butterfly fat-tree network built from `t_switch`/`t_cluster`. It sits between one client block (PE or operator) and the switch port that serves leaf `addr`. It packs client payloads into network packets and injects them through a TX FIFO. It accepts packets addressed to this leaf into an RX FIFO, and re-injects (bounces) any packet it cannot or must not keep, so the deflection network never sees backpressure.

## Interface
Parameters:
- `num_leaves`, 2: leaves in the tree. `aw = $clog2(num_leaves)`.
- `payload_sz`, 1: payload bits per packet.
- `addr`, 0: this leaf's address, `aw` bits.
- `p_sz`, `1+aw+payload_sz`: packet width.
- `fifo_depth`, 4: entries per FIFO. Power of two, ≥2.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `bus_i` in p_sz: packet from switch.
- `bus_o` out p_sz: packet to switch.
- `tx_valid` in 1: client offers a packet.
- `tx_ready` out 1: TX FIFO can accept.
- `tx_dest` in aw: destination leaf.
- `tx_data` in payload_sz: payload.
- `rx_valid` out 1: RX FIFO head valid.
- `rx_ready` in 1: client consumes head.
- `rx_data` out payload_sz: head payload.
- `rx_src_ok` out 1: high while the head entry has been stored (always 1 when `rx_valid`; reserved for future source field).
- `bounce_cnt` out 16: saturating count of bounced packets.

## Operation
- Packet layout: bit `p_sz-1` = valid. Bits `[p_sz-2 -: aw]` = destination. Bits `[payload_sz-1:0]` = payload.
- TX FIFO:
  - `tx_ready = !tx_full`, using registered occupancy.
  - Write on `tx_valid && tx_ready`, storing `{1'b1, tx_dest, tx_data}`.
  - Show-ahead head; circular pointers of `log2(fifo_depth)` bits wrap modulo depth; occupancy counter has `log2(fifo_depth)+1` bits.
- RX classification of `bus_i` when valid bit = 1:
  - dest == `addr` and RX FIFO not full → ACCEPT: write payload.
  - dest == `addr` and RX FIFO full → BOUNCE.
  - dest != `addr` (deflected) → BOUNCE.
  - valid = 0 → ignored.
- Output selection, registered into `bus_o` every cycle, priority order:
  1. BOUNCE: `bus_o <= bus_i` unchanged.
  2. TX FIFO non-empty: `bus_o <=` head, and pop.
  3. Otherwise `bus_o <= 0`.
- A bounce stalls TX injection for that cycle; the TX head is not popped.
- RX FIFO:
  - Show-ahead; `rx_valid = !rx_empty`; pop on `rx_valid && rx_ready`.
  - Full check uses pre-edge occupancy. An arrival while full bounces even if the client pops in the same cycle.
- A TX packet with dest == `addr` is injected normally; it is accepted when the network returns it.
- `bounce_cnt` increments on each BOUNCE and saturates at 16'hFFFF.

## Timing
- Reset (`reset` low, asynchronous):
  - `bus_o` = 0, `tx_ready` = 1, `rx_valid` = 0, `rx_data` = 0, `rx_src_ok` = 0, `bounce_cnt` = 0.
  - All pointers and counters = 0.
  - Release is synchronous to `clk`.
  - Reset mid-operation discards all FIFO contents; a packet in flight on `bus_o` is dropped.
- TX latency: written at edge N, the packet appears on `bus_o` after edge N+1 if no bounce. Worst case is unbounded under continuous bounces.
- RX latency: `bus_i` sampled at edge N; `rx_valid`/`rx_data` are valid after edge N.
- Bounce latency: `bus_i` at edge N appears on `bus_o` after edge N, i.e. one cycle.
- Simultaneous TX write and pop when the FIFO holds 1 entry: occupancy stays 1.
- Write on the last free slot: `tx_ready` drops the next cycle.
- Throughput: 1 packet/cycle each direction.
- `bus_o` valid bit never high without a defined destination; no combinational path from `bus_i` to `bus_o`.

## Test plan
- Reset then idle, `num_leaves=8`, `addr=3`, `payload_sz=8` → all outputs 0, `tx_ready`=1, `bus_o`=0 for 10 cycles.
- Client writes dest=5, data=0xA5 at edge N → `bus_o` = {1,3'd5,8'hA5} after N+1, then 0; `tx_ready` stays 1.
- `bus_i` = {1,3'd3,8'h3C} for one cycle at edge N → `rx_valid`=1 and `rx_data`=0x3C after N; `rx_ready`=1 clears it next edge; `bounce_cnt`=0.
- `rx_ready`=0, five packets to dest=3 with depth 4 → first four stored in order; fifth appears on `bus_o` unchanged one cycle later; `bounce_cnt`=1.
- TX FIFO holds dest=1 data=0x11 while `bus_i` = {1,3'd6,8'h77} → `bus_o` = 0x77 packet first, TX packet the following cycle; `bounce_cnt`=1.
- Fill TX FIFO (4 writes, no drain due to continuous bounces), then assert `reset` low mid-cycle → outputs clear immediately; after release `tx_ready`=1, `bus_o`=0, no stale packet emitted.
